// File: rtl/iterative_multiplier.sv
// ---------------------------------------------------------------------------
// iterative_multiplier
//
// Multi-cycle shift-add multiplier producing a full 2*WIDTH-bit product for
// MUL/UMULL/SMULL-class instructions. Shares operand naming (rn, rm) and op
// encoding with the divider unit: op=1 unsigned, op=0 signed two's complement.
// Signed operation multiplies magnitudes and negates the result at the end.
//
// Optional feature macro: MUL_EARLY_TERM_EN
//   defined   : BUSY ends as soon as the remaining multiplier bits are zero
//   undefined : fixed latency of WIDTH BUSY cycles for every operand
//
// Handshake: start is accepted on a rising edge while the FSM is in IDLE or
// DONE; rn/rm/op are sampled on that same edge. busy is high for every BUSY
// cycle. done is high for exactly one cycle (the DONE state) and y carries
// the product from that cycle until the next completion or reset. start
// while busy is ignored.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous active-high reset
//   start        in   operation request
//   rn           in   [WIDTH-1:0]    multiplicand
//   rm           in   [WIDTH-1:0]    multiplier
//   op           in   1=unsigned, 0=signed
//   busy         out  high while in BUSY
//   done         out  one-cycle completion pulse
//   y            out  [2*WIDTH-1:0] product
//   o_dbg_state  out  [1:0] FSM state (0=IDLE, 1=BUSY, 2=DONE)
// ---------------------------------------------------------------------------
module iterative_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     rn,
  input  logic [WIDTH-1:0]     rm,
  input  logic                 op,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   y,
  output logic [1:0]           o_dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_count;
  logic                 r_neg;
  logic [2*WIDTH-1:0]   r_y;

  logic                 w_accept;
  logic                 w_last;
  logic [WIDTH-1:0]     w_rn_mag;
  logic [WIDTH-1:0]     w_rm_mag;
  logic [2*WIDTH-1:0]   w_addend;
  logic [2*WIDTH-1:0]   w_sum;

  // Magnitudes: negating the most negative value wraps to itself, which is
  // exactly its magnitude when read as unsigned.
  assign w_rn_mag = (!op && rn[WIDTH-1]) ? -rn : rn;
  assign w_rm_mag = (!op && rm[WIDTH-1]) ? -rm : rm;

  assign w_addend = r_mplier[0] ? r_mcand : '0;
  assign w_sum    = r_acc + w_addend;

`ifdef MUL_EARLY_TERM_EN
  // No set bits left after this shift: remaining iterations would add zero.
  assign w_last = (r_count == CW'(WIDTH-1)) || ((r_mplier >> 1) == '0);
`else
  assign w_last = (r_count == CW'(WIDTH-1));
`endif

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = start ? S_BUSY : S_IDLE;
      S_BUSY:  w_next_state = w_last ? S_DONE : S_BUSY;
      S_DONE:  w_next_state = start ? S_BUSY : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_neg    <= 1'b0;
      r_y      <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_mcand  <= {{WIDTH{1'b0}}, w_rn_mag};
        r_mplier <= w_rm_mag;
        r_neg    <= !op && (rn[WIDTH-1] ^ rm[WIDTH-1]);
        r_acc    <= '0;
        r_count  <= '0;
      end else if (r_state == S_BUSY) begin
        r_acc    <= w_sum;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_count  <= r_count + CW'(1);
        if (w_last) begin
          r_y <= r_neg ? -w_sum : w_sum;
        end
      end
    end
  end

  assign busy        = (r_state == S_BUSY);
  assign done        = (r_state == S_DONE);
  assign y           = r_y;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_iterative_multiplier.sv
// ---------------------------------------------------------------------------
// tb_iterative_multiplier
//
// Directed bench for iterative_multiplier (WIDTH=32). A transaction-level
// model computes each product with plain arithmetic and the operation latency
// from the operand, queues the product at accept and releases it at the
// modelled completion. A compare process checks busy/done/y against that model
// on every falling edge; directed tasks additionally check hand-computed
// literal products and BUSY cycle counts.
// ---------------------------------------------------------------------------
module tb_iterative_multiplier;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic           clk;
  logic           reset;
  logic           start;
  logic [W-1:0]   rn;
  logic [W-1:0]   rm;
  logic           op;
  logic           busy;
  logic           done;
  logic [2*W-1:0] y;
  logic [1:0]     dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  iterative_multiplier #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .rn          (rn),
    .rm          (rm),
    .op          (op),
    .busy        (busy),
    .done        (done),
    .y           (y),
    .o_dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h, required 0x%016h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic [2*W-1:0] model_product(input logic [W-1:0] a,
                                                   input logic [W-1:0] b,
                                                   input logic u);
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb;
    if (u) return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    return sa * sb;
  endfunction

  function automatic int model_latency(input logic [W-1:0] b, input logic u);
`ifdef MUL_EARLY_TERM_EN
    logic [W-1:0] mag;
    int lat;
    mag = (!u && b[W-1]) ? (~b + 32'd1) : b;
    lat = 1;
    for (int i = 0; i < W; i++) if (mag[i]) lat = i + 1;
    return lat;
`else
    return W + 0 * int'(b[0] ^ u);
`endif
  endfunction

  logic [2*W-1:0] exp_q[$];
  int             m_phase;   // 0 idle, 1 computing, 2 completion cycle
  int             m_left;
  logic [2*W-1:0] m_y;
  bit             m_valid = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0;
      m_left  = 0;
      m_y     = '0;
      exp_q.delete();
      m_valid = 1;
    end else if (m_valid) begin
      if (m_phase == 1) begin
        m_left--;
        if (m_left == 0) begin
          m_y     = exp_q.pop_front();
          m_phase = 2;
        end
      end else if (start) begin
        exp_q.push_back(model_product(rn, rm, op));
        m_left  = model_latency(rm, op);
        m_phase = 1;
      end else begin
        m_phase = 0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_busy", {63'd0, busy}, {63'd0, (m_phase == 1)});
      check("cyc_done", {63'd0, done}, {63'd0, (m_phase == 2)});
      check("cyc_y", y, m_y);
    end
  end

  // ---------------- driver tasks ----------------
  // Waits for done, counting BUSY cycles seen on falling edges.
  task automatic wait_done(output int nbusy, output bit seen);
    nbusy = 0;
    seen  = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) nbusy++;
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic u, input logic [2*W-1:0] exp_y, input int exp_lat_et);
    int  nb;
    bit  seen;
    int  exp_lat;
`ifdef MUL_EARLY_TERM_EN
    exp_lat = exp_lat_et;
`else
    exp_lat = W + 0 * exp_lat_et;
`endif
    @(posedge clk); #1;
    rn = a; rm = b; op = u; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // scramble operands mid-operation; result must not change
    rn = $urandom; rm = $urandom; op = 1'($urandom_range(0, 1));
    wait_done(nb, seen);
    check({name, "_done_seen"}, {63'd0, seen}, 64'd1);
    check({name, "_y"}, y, exp_y);
    check({name, "_busy_cycles"}, 64'(nb), 64'(exp_lat));
  endtask

  // ---------------- stimulus ----------------
  int  nb;
  bit  seen;
  int  spurious;

  initial begin
    reset = 1'b1; start = 1'b0; rn = '0; rm = '0; op = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_y", y, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_op("u_ffff",      32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFE00000001, 32);
    run_op("s_m7x6",      32'hFFFFFFF9, 32'd6,        1'b0, 64'hFFFFFFFFFFFFFFD6, 3);
    run_op("u_m7x6",      32'hFFFFFFF9, 32'd6,        1'b1, 64'h00000005FFFFFFD6, 3);
    run_op("s_min_min",   32'h80000000, 32'h80000000, 1'b0, 64'h4000000000000000, 32);
    run_op("s_min_one",   32'h80000000, 32'd1,        1'b0, 64'hFFFFFFFF80000000, 1);
    run_op("u_100x1",     32'd100,      32'd1,        1'b1, 64'd100,              1);
    run_op("u_100x0",     32'd100,      32'd0,        1'b1, 64'd0,                1);
    run_op("u_100xmsb",   32'd100,      32'h80000000, 1'b1, 64'h0000003200000000, 32);
    run_op("s_0xm5",      32'd0,        32'hFFFFFFFB, 1'b0, 64'd0,                3);
    run_op("s_m3xm4",     32'hFFFFFFFD, 32'hFFFFFFFC, 1'b0, 64'd12,               3);

    // back-to-back: start held high, second operands presented at DONE
    @(posedge clk); #1;
    rn = 32'd3; rm = 32'd5; op = 1'b1; start = 1'b1;
    wait_done(nb, seen);
    check("b2b1_done_seen", {63'd0, seen}, 64'd1);
    check("b2b1_y", y, 64'd15);
    rn = 32'd2; rm = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(nb, seen);
    check("b2b2_done_seen", {63'd0, seen}, 64'd1);
    check("b2b2_y", y, 64'd18);

    // reset in the middle of an operation
    @(posedge clk); #1;
    rn = 32'hFFFFFFFF; rm = 32'hFFFFFFFF; op = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nb = 0;
    for (int k = 0; k < 100 && nb < 10; k++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_y", y, 64'd0);
    check("abort_state", {62'd0, dbg_state}, 64'd0);
    spurious = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) spurious++;
    end
    check("abort_no_spurious_done", 64'(spurious), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
